lagarto_store_buffer: RTL and testbench
=======================================

LAGARTO_STORE_BUFFER -- requirements
Module: lagarto_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (power of two, >=2).
REQ-002 SHALL use DCACHE_INDEX_WIDTH and DCACHE_TAG_WIDTH from drac_pkg for address split.
REQ-003 clk_i  in  1  clock; all state rises on posedge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 st_valid_i  in  1  store from dcache interface valid.
REQ-006 st_ready_o  out  1  buffer can accept store.
REQ-007 st_paddr_i  in  64  store physical address.
REQ-008 st_wdata_i  in  64  store data, already lane-aligned.
REQ-009 st_be_i  in  8  byte enables.
REQ-010 st_size_i  in  2  0=B,1=H,2=W,3=D.
REQ-011 st_mem_req_valid_o  out  1  dcache store-port request.
REQ-012 st_mem_req_gnt_i  in  1  dcache accepted index phase.
REQ-013 st_mem_req_addr_index_o  out  DCACHE_INDEX_WIDTH  paddr index bits.
REQ-014 st_mem_req_addr_tag_o  out  DCACHE_TAG_WIDTH  paddr tag bits.
REQ-015 st_mem_req_tag_valid_o  out  1  tag phase active.
REQ-016 st_mem_req_wdata_o/be_o/size_o/we_o/kill_o  out  64/8/2/1/1  head entry fields; we_o=1 while valid_o or tag_valid_o high, kill_o=0.
REQ-017 ld_chk_paddr_i  in  64  pending load address.
REQ-018 ld_chk_hit_o  out  1  valid entry matches load doubleword.
REQ-019 sb_empty_o  out  1  no valid entries and FSM IDLE.
REQ-020 sb_count_o  out  $clog2(DEPTH+1)  valid-entry count.

Function
REQ-021 Push: st_valid_i & st_ready_o writes entry at wr_ptr, wr_ptr+1 mod DEPTH, same edge.
REQ-022 st_ready_o SHALL equal (count != DEPTH), from registered count only; no pop-through when full.
REQ-023 Drain FSM states IDLE, INDEX, TAG.
REQ-024 IDLE -> INDEX when count != 0; INDEX: valid_o=1, index/data/be/size from head entry.
REQ-025 INDEX holds until gnt_i=1, then -> TAG next cycle.
REQ-026 TAG: exactly one cycle, tag_valid_o=1, valid_o=0, tag from head; head popped at end of TAG; -> INDEX if count after pop !=0, else IDLE.
REQ-027 Index = paddr[DCACHE_INDEX_WIDTH-1:0]; tag = paddr[DCACHE_INDEX_WIDTH+DCACHE_TAG_WIDTH-1:DCACHE_INDEX_WIDTH].
REQ-028 Push and pop in same cycle: count unchanged, both pointers advance.
REQ-029 Minimum latency push -> valid_o: 1 cycle (entry visible next cycle in IDLE->INDEX).
REQ-030 Throughput: one store per 2 cycles with gnt_i held high.
REQ-031 ld_chk_hit_o combinational: OR over valid entries of paddr[63:3]==ld_chk_paddr_i[63:3]; includes head entry in INDEX/TAG.
REQ-032 Pointers wrap modulo DEPTH; FIFO order preserved across wrap.
REQ-033 Head outputs SHALL stay stable from INDEX entry through TAG.

Reset
REQ-034 rstn_i low: all entries invalid, pointers 0, count 0, FSM IDLE, valid_o=0, tag_valid_o=0, ld_chk_hit_o=0, sb_empty_o=1, st_ready_o=1; in-flight store discarded.

Structure
REQ-035 sb_entry_t (paddr, wdata, be, size) and sb_state_t SHALL be added to drac_pkg.
REQ-036 Entry storage/pointers SHALL be sub-module lagarto_sb_fifo; FSM and match logic in top.

Verification
REQ-037 Single SD paddr 0x8000_1008 data 0xDEADBEEF_00000000, gnt_i=1 -> INDEX cycle 1, TAG cycle 2 with tag bits of 0x8000_1008, sb_empty_o=1 cycle 4.
REQ-038 Push 4 stores, gnt_i=0 -> st_ready_o=0, count=4, valid_o held, outputs stable; release gnt_i -> drained in push order, 8 cycles.
REQ-039 Full buffer, push offered during TAG pop -> rejected that cycle, accepted next cycle; count 4->3->4.
REQ-040 Entry at 0x100 buffered, ld_chk_paddr_i=0x104 -> hit=1; 0x108 -> hit=0; after drain, 0x104 -> hit=0.
REQ-041 Push 6 stores, DEPTH=4, continuous drain -> pointer wrap, correct order.
REQ-042 Assert rstn_i low during INDEX with 3 entries -> next cycle valid_o=0, count=0, st_ready_o=1.

Source files
------------

// File: rtl/drac_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : drac_pkg
// Description : Shared core types and constants. This package holds the
//               dcache address split and the store-buffer entry and drain
//               state types.
// Revision    : 1.0 - store buffer types added
// ============================================================================
package drac_pkg;

   // Dcache physical-address split: index = paddr[11:0], tag = paddr[39:12]
   localparam int DCACHE_INDEX_WIDTH = 12;
   localparam int DCACHE_TAG_WIDTH   = 28;

   // One buffered store. The data is already lane-aligned.
   typedef struct packed {
      logic [63:0] paddr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [1:0]  size;
   } sb_entry_t;

   // Store-buffer drain sequencer states
   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_INDEX = 2'd1,
      SB_TAG   = 2'd2
   } sb_state_t;

endpackage : drac_pkg
`default_nettype wire

// File: rtl/lagarto_sb_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : lagarto_sb_fifo
// Description : Circular entry storage for the store buffer.
//               The module provides write and read pointers, an occupancy
//               count and a valid bit for each entry.
// Ports       : clk_i, rstn_i         - clock and async active-low reset
//               push_i, push_entry_i  - write an entry at the write pointer
//               pop_i                 - retire the entry at the read pointer
//               head_o                - entry at the read pointer
//               count_o               - number of valid entries
//               valid_o               - valid bit for each slot
//               dw_addr_o             - paddr[63:3] of each slot
// Revision    : 1.0 - initial
// ============================================================================
module lagarto_sb_fifo
   import drac_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         push_i,
   input  sb_entry_t                    push_entry_i,
   input  logic                         pop_i,
   output sb_entry_t                    head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [DEPTH-1:0]             valid_o,
   output logic [60:0]                  dw_addr_o [DEPTH]
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   sb_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [DEPTH-1:0]   valid_q;

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         // Push and pop never target the same slot: the top blocks pushes
         // when full, and a pop needs at least one entry.
         if (pop_i)  valid_q[rd_ptr_q] <= 1'b0;
         if (push_i) valid_q[wr_ptr_q] <= 1'b1;
      end
   end

   // Payload storage needs no reset; the valid bits qualify each slot
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         dw_addr_o[i] = mem_q[i].paddr[63:3];
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign valid_o = valid_q;

endmodule : lagarto_sb_fifo
`default_nettype wire

// File: rtl/lagarto_store_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : lagarto_store_buffer
// Description : Buffers committed stores and drains them in order into the
//               dcache store port. Each drain uses a two-phase handshake:
//               an index phase that holds until granted, then one tag cycle.
//               The module also flags pending loads that overlap a buffered
//               store at doubleword granularity.
// Ports       : clk_i / rstn_i             - clock, async active-low reset
//               st_*_i / st_ready_o        - store input handshake
//               st_mem_req_*               - dcache store-port request
//               ld_chk_paddr_i / ld_chk_hit_o - load overlap check
//               sb_empty_o / sb_count_o    - occupancy status
// Revision    : 1.0 - initial
// ============================================================================
module lagarto_store_buffer
   import drac_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic                           st_valid_i,
   output logic                           st_ready_o,
   input  logic [63:0]                    st_paddr_i,
   input  logic [63:0]                    st_wdata_i,
   input  logic [7:0]                     st_be_i,
   input  logic [1:0]                     st_size_i,
   output logic                           st_mem_req_valid_o,
   input  logic                           st_mem_req_gnt_i,
   output logic [DCACHE_INDEX_WIDTH-1:0]  st_mem_req_addr_index_o,
   output logic [DCACHE_TAG_WIDTH-1:0]    st_mem_req_addr_tag_o,
   output logic                           st_mem_req_tag_valid_o,
   output logic [63:0]                    st_mem_req_wdata_o,
   output logic [7:0]                     st_mem_req_be_o,
   output logic [1:0]                     st_mem_req_size_o,
   output logic                           st_mem_req_we_o,
   output logic                           st_mem_req_kill_o,
   input  logic [63:0]                    ld_chk_paddr_i,
   output logic                           ld_chk_hit_o,
   output logic                           sb_empty_o,
   output logic [$clog2(DEPTH+1)-1:0]     sb_count_o
);

   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int ADDR_W = DCACHE_INDEX_WIDTH + DCACHE_TAG_WIDTH;

   sb_state_t          state_q, state_d;
   sb_entry_t          push_entry, head;
   logic               push, pop;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_after_pop;
   logic [DEPTH-1:0]   entry_valid;
   logic [60:0]        entry_dw [DEPTH];

   // Readiness comes only from the registered count. A full buffer does not
   // accept a store even in the cycle it pops.
   assign st_ready_o = (count != CNT_W'(DEPTH));
   assign push       = st_valid_i & st_ready_o;
   assign pop        = (state_q == SB_TAG);

   assign push_entry = '{paddr: st_paddr_i, wdata: st_wdata_i,
                         be: st_be_i, size: st_size_i};

   lagarto_sb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count),
      .valid_o      (entry_valid),
      .dw_addr_o    (entry_dw)
   );

   // Occupancy after the pop in this TAG cycle. A push in the same cycle
   // is counted, so the drain can continue without a bubble.
   assign count_after_pop = count - CNT_W'(1) + CNT_W'(push);

   // ---------------- drain FSM: state register ----------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= SB_IDLE;
      else         state_q <= state_d;
   end

   // ---------------- drain FSM: next state ----------------
   // Leaving IDLE on an incoming push gives a one-cycle push-to-valid latency
   always_comb begin
      state_d = state_q;
      case (state_q)
         SB_IDLE:  if (count != '0 || push) state_d = SB_INDEX;
         SB_INDEX: if (st_mem_req_gnt_i)    state_d = SB_TAG;
         SB_TAG:   state_d = (count_after_pop != '0) ? SB_INDEX : SB_IDLE;
         default:  state_d = SB_IDLE;
      endcase
   end

   // ---------------- drain FSM: outputs ----------------
   always_comb begin
      st_mem_req_valid_o     = 1'b0;
      st_mem_req_tag_valid_o = 1'b0;
      case (state_q)
         SB_INDEX: st_mem_req_valid_o     = 1'b1;
         SB_TAG:   st_mem_req_tag_valid_o = 1'b1;
         default:  ;
      endcase
   end

   // The head fields stay stable from INDEX through TAG because the read
   // pointer moves only at the end of TAG.
   assign st_mem_req_addr_index_o = head.paddr[DCACHE_INDEX_WIDTH-1:0];
   assign st_mem_req_addr_tag_o   = head.paddr[ADDR_W-1:DCACHE_INDEX_WIDTH];
   assign st_mem_req_wdata_o      = head.wdata;
   assign st_mem_req_be_o         = head.be;
   assign st_mem_req_size_o       = head.size;
   assign st_mem_req_we_o         = st_mem_req_valid_o | st_mem_req_tag_valid_o;
   assign st_mem_req_kill_o       = 1'b0;

   // The load check compares at doubleword granularity against every valid
   // entry, including the head while it drains.
   always_comb begin
      ld_chk_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (entry_dw[i] == ld_chk_paddr_i[63:3]))
            ld_chk_hit_o = 1'b1;
      end
   end

   assign sb_empty_o = (count == '0) && (state_q == SB_IDLE);
   assign sb_count_o = count;

   // These bits are not used: the load check ignores the byte offset, and
   // the cache port does not carry paddr bits above the tag.
   logic unused_bits;
   assign unused_bits = ^{ld_chk_paddr_i[2:0], head.paddr[63:ADDR_W]};

endmodule : lagarto_store_buffer
`default_nettype wire

// File: tb/tb_lagarto_store_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lagarto_store_buffer
// Description : Self-checking bench for lagarto_store_buffer. A queue-based
//               store-buffer model is compared against the DUT on every
//               falling edge, alongside directed literal checks.
// Revision    : 1.0 - initial
// ============================================================================
module tb_lagarto_store_buffer;
   import drac_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic                           clk = 1'b0;
   logic                           rstn = 1'b0;
   logic                           st_valid = 1'b0;
   logic                           st_ready;
   logic [63:0]                    st_paddr = '0;
   logic [63:0]                    st_wdata = '0;
   logic [7:0]                     st_be = '0;
   logic [1:0]                     st_size = '0;
   logic                           req_valid;
   logic                           gnt = 1'b0;
   logic [DCACHE_INDEX_WIDTH-1:0]  req_index;
   logic [DCACHE_TAG_WIDTH-1:0]    req_tag;
   logic                           req_tag_valid;
   logic [63:0]                    req_wdata;
   logic [7:0]                     req_be;
   logic [1:0]                     req_size;
   logic                           req_we, req_kill;
   logic [63:0]                    ld_paddr = '0;
   logic                           ld_hit;
   logic                           sb_empty;
   logic [CW-1:0]                  sb_count;

   lagarto_store_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i                   (clk),
      .rstn_i                  (rstn),
      .st_valid_i              (st_valid),
      .st_ready_o              (st_ready),
      .st_paddr_i              (st_paddr),
      .st_wdata_i              (st_wdata),
      .st_be_i                 (st_be),
      .st_size_i               (st_size),
      .st_mem_req_valid_o      (req_valid),
      .st_mem_req_gnt_i        (gnt),
      .st_mem_req_addr_index_o (req_index),
      .st_mem_req_addr_tag_o   (req_tag),
      .st_mem_req_tag_valid_o  (req_tag_valid),
      .st_mem_req_wdata_o      (req_wdata),
      .st_mem_req_be_o         (req_be),
      .st_mem_req_size_o       (req_size),
      .st_mem_req_we_o         (req_we),
      .st_mem_req_kill_o       (req_kill),
      .ld_chk_paddr_i          (ld_paddr),
      .ld_chk_hit_o            (ld_hit),
      .sb_empty_o              (sb_empty),
      .sb_count_o              (sb_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The buffer is an ordered queue of stores. The head goes through two
   // phases on the cache port: an address phase that lasts until granted,
   // then one tag cycle, after which the head is retired.
   typedef enum int {M_QUIET, M_ADDR, M_TAG} mphase_t;
   sb_entry_t mq[$];
   mphase_t   mphase = M_QUIET;

   always @(negedge clk) begin
      automatic logic exp_hit = 1'b0;
      automatic logic accepted;
      automatic int   remaining;
      if (!rstn) begin
         mq.delete();
         mphase = M_QUIET;
      end
      foreach (mq[i]) if (mq[i].paddr[63:3] == ld_paddr[63:3]) exp_hit = 1'b1;
      chk("m_ready",     st_ready,      (mq.size() != DEPTH));
      chk("m_count",     sb_count,      mq.size());
      chk("m_empty",     sb_empty,      (mq.size() == 0 && mphase == M_QUIET));
      chk("m_valid",     req_valid,     (mphase == M_ADDR));
      chk("m_tag_valid", req_tag_valid, (mphase == M_TAG));
      chk("m_we",        req_we,        (mphase != M_QUIET));
      chk("m_kill",      req_kill,      1'b0);
      chk("m_hit",       ld_hit,        exp_hit);
      if (mphase != M_QUIET && mq.size() > 0) begin
         chk("m_index", req_index, mq[0].paddr % (64'd1 << DCACHE_INDEX_WIDTH));
         chk("m_tag",   req_tag,   (mq[0].paddr >> DCACHE_INDEX_WIDTH) % (64'd1 << DCACHE_TAG_WIDTH));
         chk("m_wdata", req_wdata, mq[0].wdata);
         chk("m_be",    req_be,    mq[0].be);
         chk("m_size",  req_size,  mq[0].size);
      end
      if (rstn) begin
         accepted = st_valid && (mq.size() != DEPTH);
         if (mphase == M_TAG) begin
            void'(mq.pop_front());
            remaining = mq.size() + int'(accepted);
            mphase = (remaining != 0) ? M_ADDR : M_QUIET;
         end else if (mphase == M_ADDR) begin
            if (gnt) mphase = M_TAG;
         end else begin
            if (mq.size() != 0 || accepted) mphase = M_ADDR;
         end
         if (accepted) mq.push_back('{paddr: st_paddr, wdata: st_wdata, be: st_be, size: st_size});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one store and hold it until it is accepted (bounded)
   task automatic push_store(input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] be, input logic [1:0] sz);
      automatic bit done = 1'b0;
      st_valid = 1'b1; st_paddr = a; st_wdata = d; st_be = be; st_size = sz;
      for (int n = 0; n < 50 && !done; n++) begin
         done = st_ready;
         step();
      end
      st_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL push_timeout addr=%0h actual=not_accepted expected=accepted", a);
      end
   endtask

   task automatic drain_wait();
      automatic bit done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         if (sb_empty) done = 1'b1;
         else step();
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=not_empty expected=empty");
      end
   endtask

   initial begin
      // reset state
      step(); step();
      chk("rst_ready", st_ready, 1'b1);
      chk("rst_empty", sb_empty, 1'b1);
      chk("rst_count", sb_count, 0);
      chk("rst_valid", req_valid, 1'b0);
      chk("rst_tagv",  req_tag_valid, 1'b0);
      chk("rst_hit",   ld_hit, 1'b0);
      rstn = 1'b1;
      step();

      // single SD with immediate grant
      gnt = 1'b1;
      push_store(64'h8000_1008, 64'hDEADBEEF_00000000, 8'hF0, 2'd3);
      chk("sd_c1_valid", req_valid, 1'b1);
      chk("sd_c1_index", req_index, 12'h008);
      chk("sd_c1_wdata", req_wdata, 64'hDEADBEEF_00000000);
      step();
      chk("sd_c2_tagv",  req_tag_valid, 1'b1);
      chk("sd_c2_valid", req_valid, 1'b0);
      chk("sd_c2_tag",   req_tag, 28'h0080001);
      step(); step();
      chk("sd_c4_empty", sb_empty, 1'b1);

      // fill with grant low, then drain in eight cycles
      gnt = 1'b0;
      for (int i = 0; i < 4; i++)
         push_store(64'h1_0000_0100 + 64'(i) * 64'h88, 64'hA0 + 64'(i), 8'hFF, 2'd3);
      chk("full_ready", st_ready, 1'b0);
      chk("full_count", sb_count, 4);
      chk("full_valid", req_valid, 1'b1);
      chk("full_index", req_index, 12'h100);
      step(); step();
      chk("hold_index", req_index, 12'h100);
      chk("hold_wdata", req_wdata, 64'hA0);
      chk("hold_valid", req_valid, 1'b1);
      gnt = 1'b1;
      step(); step();
      chk("drain_c2_count", sb_count, 3);
      chk("drain_c2_index", req_index, 12'h188);
      for (int i = 0; i < 6; i++) step();
      chk("drain_c8_empty", sb_empty, 1'b1);

      // full buffer, push offered during the pop
      gnt = 1'b0;
      for (int i = 0; i < 4; i++)
         push_store(64'h2000 + 64'(i) * 8, 64'hB0 + 64'(i), 8'h0F, 2'd2);
      gnt = 1'b1;
      st_valid = 1'b1; st_paddr = 64'h3000; st_wdata = 64'hC0; st_be = 8'h01; st_size = 2'd0;
      step();
      chk("tagpop_ready", st_ready, 1'b0);
      chk("tagpop_count", sb_count, 4);
      step();
      chk("after_count", sb_count, 3);
      chk("after_ready", st_ready, 1'b1);
      step();
      st_valid = 1'b0;
      chk("refill_count", sb_count, 4);
      drain_wait();

      // load-overlap check
      gnt = 1'b0;
      push_store(64'h100, 64'h11, 8'hFF, 2'd3);
      ld_paddr = 64'h104; #1;
      chk("ld_hit_104", ld_hit, 1'b1);
      ld_paddr = 64'h108; #1;
      chk("ld_hit_108", ld_hit, 1'b0);
      ld_paddr = 64'h104;
      gnt = 1'b1;
      drain_wait();
      #1;
      chk("ld_hit_drained", ld_hit, 1'b0);
      ld_paddr = 64'h0;

      // six stores through a four-entry buffer while draining
      for (int i = 0; i < 6; i++)
         push_store(64'h4000 + 64'(i) * 64'h10, 64'hD0 + 64'(i), 8'hFF, 2'd3);
      drain_wait();

      // reset while in the index phase
      gnt = 1'b0;
      for (int i = 0; i < 3; i++)
         push_store(64'h5000 + 64'(i) * 8, 64'hE0 + 64'(i), 8'hFF, 2'd3);
      chk("prerst_valid", req_valid, 1'b1);
      rstn = 1'b0;
      step();
      chk("mrst_valid", req_valid, 1'b0);
      chk("mrst_count", sb_count, 0);
      chk("mrst_ready", st_ready, 1'b1);
      rstn = 1'b1;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_lagarto_store_buffer
`default_nettype wire
